// File: rtl/pc_redirect_unit.sv
// PC redirect unit: owns the fetch PC, sequences redirects coming back from
// the execute stage, holds a redirect while the pipe is stalled, and raises
// Flush for a programmable number of cycles after each PC change. Redirect
// targets that are not word aligned are replaced by the exception vector and
// reported through AlignErr/ErrPC.
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        RedirValid,
    input  logic [31:0] RedirTarget,
    output logic        RedirReady,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        FetchValid,
    output logic        Flush,
    output logic        AlignErr,
    output logic [31:0] ErrPC
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PEND  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    // Counter reload value; FLUSH lasts one cycle more than the loaded count.
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    state_t      state_q,     state_d;
    logic [31:0] pc_q,        pc_d;
    logic [31:0] pend_q,      pend_d;
    logic [2:0]  cnt_q,       cnt_d;
    logic        align_err_q, align_err_d;
    logic [31:0] err_pc_q,    err_pc_d;

    logic        accept_s;
    logic        misaligned_s;
    logic [31:0] eff_target_s;

    // Redirect handshake and target qualification.
    always_comb begin
        accept_s     = RedirValid && (state_q == ST_RUN);
        misaligned_s = (RedirTarget[1:0] != 2'b00);
        if (misaligned_s) begin
            eff_target_s = EXC_VECTOR;
        end else begin
            eff_target_s = RedirTarget;
        end
    end

    // Next-state and next-register computation for the redirect sequencer.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_d      = pend_q;
        cnt_d       = cnt_q;
        align_err_d = 1'b0;
        err_pc_d    = err_pc_q;

        case (state_q)
            ST_INIT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (accept_s) begin
                    if (misaligned_s) begin
                        align_err_d = 1'b1;
                        err_pc_d    = RedirTarget;
                    end else begin
                        err_pc_d    = err_pc_q;
                    end
                    if (Stall) begin
                        // Park the target until the hazard clears.
                        pend_d  = eff_target_s;
                        state_d = ST_PEND;
                    end else begin
                        pc_d    = eff_target_s;
                        cnt_d   = FLUSH_LOAD;
                        state_d = ST_FLUSH;
                    end
                end else if (!Stall) begin
                    pc_d = pc_q + 32'd4;
                end else begin
                    pc_d = pc_q;
                end
            end
            ST_PEND: begin
                if (!Stall) begin
                    pc_d    = pend_q;
                    cnt_d   = FLUSH_LOAD;
                    state_d = ST_FLUSH;
                end else begin
                    pc_d = pc_q;
                end
            end
            ST_FLUSH: begin
                // The flush window runs on wall-clock cycles, stall or not.
                if (cnt_q == 3'd0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = ST_INIT;
                pc_d    = RESET_PC;
                pend_d  = 32'h0000_0000;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= ST_INIT;
            pc_q        <= RESET_PC;
            pend_q      <= 32'h0000_0000;
            cnt_q       <= 3'd0;
            align_err_q <= 1'b0;
            err_pc_q    <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_q      <= pend_d;
            cnt_q       <= cnt_d;
            align_err_q <= align_err_d;
            err_pc_q    <= err_pc_d;
        end
    end

    // Output decode: PC-related values come straight from flops, the
    // handshake/qualifier signals are decoded from state and Stall.
    always_comb begin
        PC         = pc_q;
        PCPlus4    = pc_q + 32'd4;
        AlignErr   = align_err_q;
        ErrPC      = err_pc_q;
        RedirReady = (state_q == ST_RUN);
        FetchValid = (state_q == ST_RUN) && !Stall;
        Flush      = (state_q == ST_FLUSH) || (state_q == ST_PEND);
    end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Self-checking bench for pc_redirect_unit: directed vector table, hand
// sequences for stall/flush/reset corners, and randomized traffic compared
// against a transaction-level reference model.
module tb_pc_redirect_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] EXC_PC = 32'h8000_0180;
    localparam int          FC     = 2;

    logic        Clk;
    logic        Reset;
    logic        Stall;
    logic        RedirValid;
    logic [31:0] RedirTarget;
    logic        RedirReady;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        FetchValid;
    logic        Flush;
    logic        AlignErr;
    logic [31:0] ErrPC;

    int total = 0;
    int bad   = 0;

    pc_redirect_unit #(
        .RESET_PC    (RST_PC),
        .EXC_VECTOR  (EXC_PC),
        .FLUSH_CYCLES(FC)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Stall      (Stall),
        .RedirValid (RedirValid),
        .RedirTarget(RedirTarget),
        .RedirReady (RedirReady),
        .PC         (PC),
        .PCPlus4    (PCPlus4),
        .FetchValid (FetchValid),
        .Flush      (Flush),
        .AlignErr   (AlignErr),
        .ErrPC      (ErrPC)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ---------------- reference model (transaction level) ----------------
    bit          m_started;     // INIT cycle already consumed
    logic [31:0] m_pend[$];     // redirect waiting for stall to clear
    int          m_flush_left;  // flush cycles still to be shown
    logic [31:0] m_pc;
    logic        m_align;
    logic [31:0] m_errpc;

    function automatic logic m_ready();
        return m_started && (m_pend.size() == 0) && (m_flush_left == 0);
    endfunction

    function automatic logic m_flush();
        return (m_pend.size() != 0) || (m_flush_left > 0);
    endfunction

    task automatic model_reset();
        m_started    = 1'b0;
        m_pend.delete();
        m_flush_left = 0;
        m_pc         = RST_PC;
        m_align      = 1'b0;
        m_errpc      = 32'h0000_0000;
    endtask

    task automatic model_edge(input logic st, input logic v, input logic [31:0] t);
        logic [31:0] eff;
        m_align = 1'b0;
        if (!m_started) begin
            m_started = 1'b1;
        end else if (m_pend.size() != 0) begin
            if (!st) begin
                m_pc = m_pend.pop_front();
                m_flush_left = FC;
            end
        end else if (m_flush_left > 0) begin
            m_flush_left = m_flush_left - 1;
        end else if (v) begin
            eff = (t % 4 == 0) ? t : EXC_PC;
            if (t % 4 != 0) begin
                m_align = 1'b1;
                m_errpc = t;
            end
            if (st) m_pend.push_back(eff);
            else begin
                m_pc = eff;
                m_flush_left = FC;
            end
        end else if (!st) begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    // ---------------- comparison helpers ----------------
    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        chk32("pc",      PC,         m_pc);
        chk32("pcplus4", PCPlus4,    m_pc + 32'd4);
        chk1 ("ready",   RedirReady, m_ready());
        chk1 ("flush",   Flush,      m_flush());
        chk1 ("fetchv",  FetchValid, m_ready() && !Stall);
        chk1 ("alignerr",AlignErr,   m_align);
        chk32("errpc",   ErrPC,      m_errpc);
    endtask

    // One clock: update model at the edge, drive the next cycle's inputs,
    // then compare at the falling edge.
    task automatic advance(input logic st, input logic v, input logic [31:0] t);
        @(posedge Clk);
        model_edge(Stall, RedirValid, RedirTarget);
        #1;
        Stall       = st;
        RedirValid  = v;
        RedirTarget = t;
        @(negedge Clk);
        model_check();
    endtask

    typedef struct {
        logic        st;
        logic        v;
        logic [31:0] t;
        logic [31:0] pc;
        logic        fl;
        logic        fv;
        logic        rdy;
        logic        al;
    } vec_t;

    vec_t tbl[13];

    initial begin
        logic        hold;
        logic        nv;
        logic [31:0] nt;

        tbl[0]  = '{1'b0, 1'b0, 32'h0,      32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 32'h0,      32'h0000_0004, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 32'h0,      32'h0000_0008, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 32'h100,    32'h0000_000C, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 32'h0,      32'h0000_0100, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 32'h0,      32'h0000_0100, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 32'h0,      32'h0000_0100, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 32'h2002,   32'h0000_0104, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 32'h0,      32'h8000_0180, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 32'h0,      32'h8000_0180, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 32'h0,      32'h8000_0180, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 32'h0,      32'h8000_0180, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 32'h0,      32'h8000_0184, 1'b0, 1'b1, 1'b1, 1'b0};

        Reset = 1'b0; Stall = 1'b0; RedirValid = 1'b0; RedirTarget = 32'h0;
        model_reset();
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk32("rst_pc", PC, RST_PC);
        chk1 ("rst_flush", Flush, 1'b0);
        chk1 ("rst_ready", RedirReady, 1'b0);
        chk1 ("rst_fetchv", FetchValid, 1'b0);
        @(posedge Clk);
        #1 Reset = 1'b1;
        @(negedge Clk);
        model_check();                       // INIT cycle
        chk1("init_ready", RedirReady, 1'b0);

        // Directed vector table
        for (int i = 0; i < 13; i++) begin
            advance(tbl[i].st, tbl[i].v, tbl[i].t);
            chk32($sformatf("vec%0d_pc", i), PC, tbl[i].pc);
            chk1 ($sformatf("vec%0d_flush", i), Flush, tbl[i].fl);
            chk1 ($sformatf("vec%0d_fetchv", i), FetchValid, tbl[i].fv);
            chk1 ($sformatf("vec%0d_ready", i), RedirReady, tbl[i].rdy);
            chk1 ($sformatf("vec%0d_align", i), AlignErr, tbl[i].al);
        end
        chk32("misalign_errpc", ErrPC, 32'h0000_2002);

        // Redirect from 0x00400010 to 0x00400100, unstalled
        advance(1'b0, 1'b1, 32'h0040_0010);
        advance(1'b0, 1'b0, 32'h0);
        advance(1'b0, 1'b0, 32'h0);
        advance(1'b0, 1'b1, 32'h0040_0100);
        chk32("seq34_pc0", PC, 32'h0040_0010);
        advance(1'b0, 1'b0, 32'h0);
        chk32("seq34_pc1", PC, 32'h0040_0100);
        chk1 ("seq34_fl1", Flush, 1'b1);
        advance(1'b0, 1'b0, 32'h0);
        chk1 ("seq34_fv2", FetchValid, 1'b0);
        advance(1'b0, 1'b0, 32'h0);
        chk1 ("seq34_fv3", FetchValid, 1'b1);
        advance(1'b0, 1'b0, 32'h0);
        chk32("seq34_pc4", PC, 32'h0040_0104);

        // Redirect accepted under a 3-cycle stall
        advance(1'b1, 1'b1, 32'h0000_2000);
        advance(1'b1, 1'b0, 32'h0);
        chk1 ("seq35_fl_a", Flush, 1'b1);
        chk32("seq35_pc_a", PC, 32'h0040_0108);
        advance(1'b1, 1'b0, 32'h0);
        chk32("seq35_pc_b", PC, 32'h0040_0108);
        advance(1'b0, 1'b0, 32'h0);
        chk1 ("seq35_fl_c", Flush, 1'b1);
        advance(1'b0, 1'b0, 32'h0);
        chk32("seq35_pc_d", PC, 32'h0000_2000);
        chk1 ("seq35_fl_d", Flush, 1'b1);
        advance(1'b0, 1'b0, 32'h0);
        chk1 ("seq35_fl_e", Flush, 1'b1);
        advance(1'b0, 1'b0, 32'h0);
        chk1 ("seq35_fv_f", FetchValid, 1'b1);

        // PC wrap at the top of the address space
        advance(1'b0, 1'b1, 32'hFFFF_FFF8);
        advance(1'b0, 1'b0, 32'h0);
        advance(1'b0, 1'b0, 32'h0);
        advance(1'b0, 1'b0, 32'h0);
        advance(1'b0, 1'b0, 32'h0);
        chk32("wrap_pc_a", PC, 32'hFFFF_FFFC);
        chk32("wrap_p4_a", PCPlus4, 32'h0000_0000);
        advance(1'b0, 1'b0, 32'h0);
        chk32("wrap_pc_b", PC, 32'h0000_0000);
        chk32("wrap_p4_b", PCPlus4, 32'h0000_0004);

        // Reset mid-FLUSH while a second redirect is held
        advance(1'b0, 1'b1, 32'h0000_5000);
        advance(1'b0, 1'b1, 32'h0000_6000);
        chk1("rst38_inflush", Flush, 1'b1);
        #2 Reset = 1'b0;
        #1;
        model_reset();
        chk32("rst38_pc", PC, RST_PC);
        chk1 ("rst38_flush", Flush, 1'b0);
        chk1 ("rst38_ready", RedirReady, 1'b0);
        @(posedge Clk);
        #1 Reset = 1'b1;
        @(negedge Clk);
        model_check();
        chk1("rst38_init_ready", RedirReady, 1'b0);
        advance(1'b0, 1'b1, 32'h0000_6000);
        chk1("rst38_run_ready", RedirReady, 1'b1);
        advance(1'b0, 1'b0, 32'h0);
        chk32("rst38_newpc", PC, 32'h0000_6000);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            hold = RedirValid && !m_ready();
            if (hold) begin
                nv = 1'b1;
                nt = RedirTarget;
            end else begin
                nv = ($urandom_range(2) == 0);
                nt = $urandom;
                if ($urandom_range(3) != 0) nt[1:0] = 2'b00;
                if ($urandom_range(15) == 0) nt = 32'hFFFF_FFFC;
            end
            advance(($urandom_range(9) < 3) ? 1'b1 : 1'b0, nv, nt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_redirect_unit.md
PC_REDIRECT_UNIT -- requirements
Module: pc_redirect_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter EXC_VECTOR, default 32'h8000_0180: PC loaded when a misaligned redirect target is accepted.
REQ-003 Parameter FLUSH_CYCLES, default 2, legal range 1..7: number of cycles Flush stays high per redirect.
REQ-004 Clk  input  1  rising-edge clock for all state.
REQ-005 Reset  input  1  asynchronous, active-low reset; 0 forces reset state immediately.
REQ-006 Stall  input  1  hazard stall; 1 holds PC.
REQ-007 RedirValid  input  1  redirect request from execute stage.
REQ-008 RedirTarget  input  32  full target address (jump target = {PC[31:28], index<<2}, branch target, or register target).
REQ-009 RedirReady  output  1  unit can accept a redirect this cycle.
REQ-010 PC  output  32  current fetch address.
REQ-011 PCPlus4  output  32  PC+4, combinational, modulo 2^32.
REQ-012 FetchValid  output  1  instruction memory output at PC is valid for IF/ID.
REQ-013 Flush  output  1  kill younger instructions in IF/ID and ID/EX.
REQ-014 AlignErr  output  1  one-cycle pulse: accepted target had RedirTarget[1:0] != 0.
REQ-015 ErrPC  output  32  last misaligned target accepted.

Function
REQ-016 States: INIT, RUN, PEND, FLUSH; 32-bit pending-target register; 3-bit flush counter.
REQ-017 Handshake: redirect accepted on a rising edge where RedirValid=1 and RedirReady=1; RedirReady = (state==RUN), combinational.
REQ-018 RedirValid while RedirReady=0 is ignored; the requester holds RedirValid until accepted.
REQ-019 INIT: PC held, FetchValid=0, Flush=0; unconditional transition to RUN on next edge.
REQ-020 RUN, no accept, Stall=0: PC <= PC+4, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-021 RUN, no accept, Stall=1: PC held.
REQ-022 RUN, accept, Stall=0: PC <= effective target; counter <= FLUSH_CYCLES-1; go to FLUSH.
REQ-023 RUN, accept, Stall=1: pending <= effective target; PC held; go to PEND.
REQ-024 Effective target = RedirTarget if RedirTarget[1:0]==0, else EXC_VECTOR.
REQ-025 Misaligned accept: AlignErr=1 for exactly the cycle after the accepting edge; ErrPC <= RedirTarget on that edge.
REQ-026 PEND: PC held; when Stall=0 at an edge, PC <= pending, counter <= FLUSH_CYCLES-1, go to FLUSH.
REQ-027 FLUSH: Flush=1, FetchValid=0, PC held; counter decrements each edge regardless of Stall; at counter==0 the next edge goes to RUN.
REQ-028 Flush = (state==FLUSH) or (state==PEND); FetchValid = (state==RUN) and Stall==0.
REQ-029 Redirect latency: new PC visible one edge after acceptance when unstalled; FetchValid returns FLUSH_CYCLES edges after PC update.
REQ-030 Outputs other than PCPlus4, RedirReady, FetchValid and Flush are registered.

Reset
REQ-031 Reset=0 asynchronously sets state=INIT, PC=RESET_PC, pending=0, counter=0, AlignErr=0, ErrPC=0; FetchValid=0, Flush=0, RedirReady=0.
REQ-032 Reset asserted in any state, including mid-FLUSH or PEND, discards pending redirects; after release the sequence restarts from INIT.

Verification
REQ-033 Reset release, Stall=0, no redirects -> INIT for one cycle, then PC=0,4,8,12 on successive edges with FetchValid=1.
REQ-034 PC=32'h0040_0010, RedirTarget=32'h0040_0100 accepted, Stall=0 -> PC=32'h0040_0100 next edge; Flush=1 and FetchValid=0 for 2 cycles; then PC=32'h0040_0104.
REQ-035 Redirect to 32'h0000_2000 accepted with Stall=1 for 3 cycles -> PC held and Flush=1 through the stall; PC=32'h0000_2000 on the first unstalled edge, then a 2-cycle flush.
REQ-036 Redirect to 32'h0000_2002 accepted -> PC=32'h8000_0180, AlignErr=1 for one cycle, ErrPC=32'h0000_2002.
REQ-037 PC=32'hFFFF_FFFC, Stall=0 -> PC=32'h0000_0000 next edge, PCPlus4=32'h0000_0004.
REQ-038 Reset pulsed low mid-FLUSH with a second RedirValid held -> PC=RESET_PC immediately; the held request is accepted only after the INIT cycle.
